dec_ssm_bit_funnel: RTL and testbench

Per-substream bit funnel directly upstream of the BP block decoder. It accepts 64-bit bitstream words from the substream demux FIFO and holds up to 256 bits. It presents an MSB-aligned 128-bit suffix window to the block decoder. Each cycle it retires exactly the number of bits the decoder reports as consumed (bp_size) and refills from the word stream.

---
 rtl/dec_ssm_bit_funnel.sv | 135 +++++++++++++
 tb/tb_dec_ssm_bit_funnel.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_ssm_bit_funnel.sv
// Per-substream bit funnel feeding the BP block decoder.
//
// Accepts 64-bit bitstream words (bit 63 first in stream order) and keeps up to
// 256 bits MSB-aligned in buf_q. The top 128 bits form the decoder's suffix
// window. Each cycle the decoder retires consume_bits from the top, and at most
// one new word is appended directly below the post-shift valid region.
//
// Ports:
//   clk, rst       block clock, asynchronous active-high reset
//   flush          synchronous clear of buffer and counters (slice start)
//   in_valid/in_ready/in_data   word input handshake
//   suffix         128-bit window, bit 127 is the next unconsumed bit
//   suffix_valid   at least 128 valid bits held
//   consume_en/consume_bits     bits retired by the decoder this cycle (0..128)
//   fullness       valid bits held (0..256)
//   bits_consumed  running count of retired bits, wraps modulo 2^24
//   err_underflow  sticky flag for an illegal consume; cleared by rst/flush
module dec_ssm_bit_funnel #(
  parameter int unsigned ssm_idx = 0,
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned BUF_W   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  output logic [BUF_W/2-1:0]   suffix,
  output logic                 suffix_valid,
  input  logic                 consume_en,
  input  logic [7:0]           consume_bits,
  output logic [8:0]           fullness,
  output logic [23:0]          bits_consumed,
  output logic                 err_underflow
);

  localparam int unsigned WinW = BUF_W / 2;
  // Largest post-shift fullness at which a whole word still fits.
  localparam logic [8:0] LoadLimit = 9'(BUF_W - WORD_W);
  localparam logic [8:0] WinBits   = 9'(WinW);
  localparam logic [8:0] WordBits  = 9'(WORD_W);

  // Only the 64/256 geometry is supported; ssm_idx is a debug tag only.
  if (WORD_W != 64 || BUF_W != 4 * WORD_W) begin : g_param_check
    $error("dec_ssm_bit_funnel[%0d]: unsupported WORD_W/BUF_W", ssm_idx);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [8:0]       fullness_q, fullness_d;
  logic [23:0]      bits_consumed_q, bits_consumed_d;
  logic             err_q, err_d;

  // ---------------------------------------------------------------------------
  // Consume decode
  // ---------------------------------------------------------------------------
  logic       window_full;
  logic       consume_legal;
  logic       consume_illegal;
  logic [7:0] shift_amt;
  logic [8:0] post_shift_fullness;
  logic       load;

  assign window_full     = (fullness_q >= WinBits);
  assign consume_legal   = consume_en && window_full && (consume_bits <= 8'(WinW));
  assign consume_illegal = consume_en && !consume_legal;
  assign shift_amt       = consume_legal ? consume_bits : 8'd0;

  // Legal consumes never exceed fullness, so this cannot wrap.
  assign post_shift_fullness = fullness_q - {1'b0, shift_amt};

  // Depends on this cycle's consume so a word can land in the space being freed.
  // Held low during flush so a word offered that cycle stays with the FIFO.
  assign in_ready = !flush && (post_shift_fullness <= LoadLimit);
  assign load     = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next state: shift out retired bits, then append at the post-shift fullness
  // ---------------------------------------------------------------------------
  logic [BUF_W-1:0] buf_shifted;
  logic [BUF_W-1:0] word_aligned;

  always_comb begin
    buf_shifted  = buf_q << shift_amt;
    // post_shift_fullness <= 192 whenever load is set, so no word bits fall off.
    word_aligned = {in_data, {(BUF_W - WORD_W){1'b0}}} >> post_shift_fullness;
  end

  always_comb begin
    buf_d           = buf_q;
    fullness_d      = fullness_q;
    bits_consumed_d = bits_consumed_q;
    err_d           = err_q;
    if (flush) begin
      buf_d           = '0;
      fullness_d      = '0;
      bits_consumed_d = '0;
      err_d           = 1'b0;
    end else begin
      buf_d           = buf_shifted | (load ? word_aligned : '0);
      fullness_d      = post_shift_fullness + (load ? WordBits : 9'd0);
      bits_consumed_d = bits_consumed_q + {16'd0, shift_amt};
      if (consume_illegal) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q           <= '0;
      fullness_q      <= '0;
      bits_consumed_q <= '0;
      err_q           <= 1'b0;
    end else begin
      buf_q           <= buf_d;
      fullness_q      <= fullness_d;
      bits_consumed_q <= bits_consumed_d;
      err_q           <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign suffix        = buf_q[BUF_W-1 -: WinW];
  assign suffix_valid  = window_full;
  assign fullness      = fullness_q;
  assign bits_consumed = bits_consumed_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_dec_ssm_bit_funnel.sv
// Self-checking bench for dec_ssm_bit_funnel. The reference model is a plain
// queue of stream bits: loads push 64 bits (MSB first), legal consumes pop from
// the front, and the expected window is the first 128 queued bits.
module tb_dec_ssm_bit_funnel;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [127:0] suffix;
  logic         suffix_valid;
  logic         consume_en;
  logic [7:0]   consume_bits;
  logic [8:0]   fullness;
  logic [23:0]  bits_consumed;
  logic         err_underflow;

  dec_ssm_bit_funnel #(
    .ssm_idx(0),
    .WORD_W (64),
    .BUF_W  (256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .suffix       (suffix),
    .suffix_valid (suffix_valid),
    .consume_en   (consume_en),
    .consume_bits (consume_bits),
    .fullness     (fullness),
    .bits_consumed(bits_consumed),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          mq[$];
  int unsigned m_cnt;
  bit          m_err;
  bit          m_acc;

  function automatic logic [127:0] m_suffix();
    logic [127:0] s = '0;
    for (int i = 0; i < 128; i++) begin
      if (i < mq.size()) s[127-i] = mq[i];
    end
    return s;
  endfunction

  function automatic int m_shift();
    if (consume_en && mq.size() >= 128 && consume_bits <= 8'd128) return int'(consume_bits);
    return 0;
  endfunction

  function automatic bit m_ready();
    return !flush && (int'(mq.size()) - m_shift()) <= 192;
  endfunction

  function automatic logic [8:0] m_full();
    return 9'(mq.size());
  endfunction

  task automatic model_clear();
    mq.delete();
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // Apply one clock edge to DUT and model; returns at edge + 1.
  task automatic tick();
    int  c;
    bit  ld;
    bit  bad;
    c   = m_shift();
    ld  = in_valid && m_ready();
    bad = consume_en && (mq.size() < 128 || consume_bits > 8'd128);
    @(posedge clk);
    if (flush) begin
      model_clear();
    end else begin
      if (bad) m_err = 1'b1;
      for (int i = 0; i < c; i++) void'(mq.pop_front());
      if (ld) for (int i = 63; i >= 0; i--) mq.push_back(in_data[i]);
      m_cnt = (m_cnt + c) % (1 << 24);
    end
    m_acc = ld;
    #1;
  endtask

  task automatic idle();
    flush        = 1'b0;
    in_valid     = 1'b0;
    consume_en   = 1'b0;
    consume_bits = 8'd0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %b expected 0", in_ready);
    end
    in_valid = 1'b1;
    tick();
    idle();
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    in_data = '0;
    rst = 1'b1;
    model_clear();
    #2;
    checks++;
    if (fullness !== 9'd0 || suffix !== 128'd0 || suffix_valid !== 1'b0 || in_ready !== 1'b1 ||
        bits_consumed !== 24'd0 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got full=%0d sv=%b rdy=%b cnt=%0d err=%b sfx=%h expected 0/0/1/0/0/0",
               fullness, suffix_valid, in_ready, bits_consumed, err_underflow, suffix);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    in_valid = 1'b1;
    in_data  = 64'hFFFF_0000_AAAA_5555;
    tick();
    checks++;
    if (fullness !== 9'd64 || suffix_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_first: got full=%0d sv=%b expected 64/0", fullness, suffix_valid);
    end
    in_data = 64'h0123_4567_89AB_CDEF;
    tick();
    in_valid = 1'b0;
    checks++;
    if (fullness !== 9'd128 || suffix_valid !== 1'b1) begin
      errors++;
      $display("FAIL fill_second: got full=%0d sv=%b expected 128/1", fullness, suffix_valid);
    end
    checks++;
    if (suffix !== 128'hFFFF0000AAAA5555_0123456789ABCDEF) begin
      errors++;
      $display("FAIL fill_suffix: got %h expected %h", suffix,
               128'hFFFF0000AAAA5555_0123456789ABCDEF);
    end
  endtask

  task automatic test_steady();
    bit over = 1'b0;
    in_valid     = 1'b1;
    in_data      = {$urandom, $urandom};
    consume_en   = 1'b1;
    consume_bits = 8'd37;
    for (int i = 0; i < 50; i++) begin
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++;
        $display("FAIL steady_ready[%0d]: got %b expected %b", i, in_ready, m_ready());
      end
      tick();
      if (fullness > 9'd256) over = 1'b1;
      checks++;
      if (suffix !== m_suffix() || fullness !== m_full()) begin
        errors++;
        $display("FAIL steady_window[%0d]: got full=%0d sfx=%h expected full=%0d sfx=%h",
                 i, fullness, suffix, m_full(), m_suffix());
      end
      if (m_acc) in_data = {$urandom, $urandom};
    end
    idle();
    checks++;
    if (bits_consumed !== 24'd1850 || over) begin
      errors++;
      $display("FAIL steady_count: got cnt=%0d overfill=%b expected 1850/0", bits_consumed, over);
    end
  endtask

  task automatic test_boundary();
    logic [127:0] prev;
    do_flush();
    load_words(4);
    checks++;
    if (fullness !== 9'd256 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bnd_full: got full=%0d rdy=%b expected 256/0", fullness, in_ready);
    end
    consume_en   = 1'b1;
    consume_bits = 8'd128;
    in_valid     = 1'b1;
    in_data      = {$urandom, $urandom};
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bnd_ready128: got %b expected 1", in_ready);
    end
    tick();
    idle();
    checks++;
    if (fullness !== 9'd192 || suffix !== m_suffix() || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bnd_consume128: got full=%0d rdy=%b sfx=%h expected 192/1 sfx=%h",
               fullness, in_ready, suffix, m_suffix());
    end
    prev         = suffix;
    consume_en   = 1'b1;
    consume_bits = 8'd0;
    tick();
    checks++;
    if (fullness !== 9'd192 || suffix !== prev || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL bnd_consume0: got full=%0d err=%b sfx=%h expected 192/0 sfx=%h",
               fullness, err_underflow, suffix, prev);
    end
    consume_bits = 8'd129;
    tick();
    idle();
    checks++;
    if (err_underflow !== 1'b1 || fullness !== 9'd192 || suffix !== prev ||
        bits_consumed !== 24'(m_cnt)) begin
      errors++;
      $display("FAIL bnd_consume129: got err=%b full=%0d cnt=%0d expected 1/192/%0d",
               err_underflow, fullness, bits_consumed, m_cnt);
    end
  endtask

  task automatic test_underflow();
    logic [127:0] prev;
    do_flush();
    load_words(1);
    prev         = suffix;
    consume_en   = 1'b1;
    consume_bits = 8'd5;
    tick();
    idle();
    checks++;
    if (err_underflow !== 1'b1 || fullness !== 9'd64 || suffix !== prev) begin
      errors++;
      $display("FAIL uflow_set: got err=%b full=%0d sfx=%h expected 1/64 sfx=%h",
               err_underflow, fullness, suffix, prev);
    end
    do_flush();
    checks++;
    if (err_underflow !== 1'b0 || fullness !== 9'd0 || bits_consumed !== 24'd0 ||
        suffix !== 128'd0) begin
      errors++;
      $display("FAIL uflow_flush: got err=%b full=%0d cnt=%0d expected 0/0/0",
               err_underflow, fullness, bits_consumed);
    end
  endtask

  task automatic test_backpressure();
    do_flush();
    load_words(4);
    consume_en   = 1'b1;
    consume_bits = 8'd56;
    tick();
    consume_bits = 8'd0;
    in_valid     = 1'b1;
    in_data      = {$urandom, $urandom};
    #1;
    checks++;
    if (fullness !== 9'd200 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: got full=%0d rdy=%b expected 200/0", fullness, in_ready);
    end
    tick();
    checks++;
    if (fullness !== 9'd200) begin
      errors++;
      $display("FAIL bp_hold: got full=%0d expected 200", fullness);
    end
    consume_bits = 8'd8;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b expected 1", in_ready);
    end
    tick();
    idle();
    checks++;
    if (fullness !== 9'd256 || suffix !== m_suffix()) begin
      errors++;
      $display("FAIL bp_accept: got full=%0d sfx=%h expected 256 sfx=%h",
               fullness, suffix, m_suffix());
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] w0;
    logic [63:0] w1;
    do_flush();
    load_words(3);
    consume_en   = 1'b1;
    consume_bits = 8'd42;
    tick();
    idle();
    checks++;
    if (fullness !== 9'd150) begin
      errors++;
      $display("FAIL arst_pre: got full=%0d expected 150", fullness);
    end
    #1;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (fullness !== 9'd0 || suffix_valid !== 1'b0 || in_ready !== 1'b1 || suffix !== 128'd0) begin
      errors++;
      $display("FAIL arst_drop: got full=%0d sv=%b rdy=%b expected 0/0/1",
               fullness, suffix_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    w0 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    in_valid = 1'b1;
    in_data  = w0;
    tick();
    in_data  = w1;
    tick();
    idle();
    checks++;
    if (suffix !== {w0, w1} || fullness !== 9'd128 || bits_consumed !== 24'd0) begin
      errors++;
      $display("FAIL arst_refill: got full=%0d sfx=%h expected 128 sfx=%h",
               fullness, suffix, {w0, w1});
    end
  endtask

  task automatic test_random();
    in_data = {$urandom, $urandom};
    for (int i = 0; i < 400; i++) begin
      flush        = ($urandom_range(0, 49) == 0);
      consume_en   = ($urandom_range(0, 3) != 0);
      consume_bits = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(129, 255))
                                                 : 8'($urandom_range(0, 128));
      in_valid     = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", i, in_ready, m_ready());
      end
      tick();
      checks++;
      if (fullness !== m_full() || suffix !== m_suffix() ||
          suffix_valid !== (mq.size() >= 128) || bits_consumed !== 24'(m_cnt) ||
          err_underflow !== m_err) begin
        errors++;
        $display("FAIL rand_state[%0d]: got full=%0d cnt=%0d err=%b sv=%b expected %0d/%0d/%b",
                 i, fullness, bits_consumed, err_underflow, suffix_valid, m_full(), m_cnt, m_err);
      end
      if (m_acc) in_data = {$urandom, $urandom};
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_steady();
    test_boundary();
    test_underflow();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
